// File: rtl/div_scheduler.sv
// In-order queue of divide/remainder ops feeding a single multi-cycle divider, with
// CDB arbitration for the finished result and flush handling for in-flight work.
module div_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [3:0]               disp_rob,
    input  logic [3:0]               disp_op,
    input  logic [31:0]              disp_a,
    input  logic [31:0]              disp_b,
    output logic                     div_valid_in,
    input  logic                     div_ready,
    output logic [3:0]               div_rob,
    output logic [3:0]               div_op,
    output logic [31:0]              div_dividend,
    output logic [31:0]              div_divisor,
    input  logic                     div_valid_out,
    input  logic [3:0]               div_rob_done,
    input  logic [31:0]              div_result,
    output logic                     div_yumi,
    output logic                     cdb_req,
    input  logic                     cdb_gnt,
    output logic [3:0]               cdb_rob,
    output logic [31:0]              cdb_result,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e            state_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;

    logic [3:0]        rob_mem [DEPTH];
    logic [3:0]        op_mem  [DEPTH];
    logic [31:0]       a_mem   [DEPTH];
    logic [31:0]       b_mem   [DEPTH];

    logic push, pop;

    // Ready depends only on registered occupancy, never on a same-cycle issue.
    assign disp_ready = (count_q < DepthCnt);
    assign push       = disp_valid & disp_ready & ~flush;
    assign pop        = (state_q == StIdle) & (count_q != '0) & div_ready & ~flush;

    assign div_valid_in = pop;
    assign div_rob      = rob_mem[rd_ptr_q];
    assign div_op       = op_mem[rd_ptr_q];
    assign div_dividend = a_mem[rd_ptr_q];
    assign div_divisor  = b_mem[rd_ptr_q];

    // A flush in BUSY kills the broadcast that same cycle; DRAIN silently discards.
    assign cdb_req    = (state_q == StBusy) & div_valid_out & ~flush;
    assign cdb_rob    = div_rob_done;
    assign cdb_result = div_result;

    always_comb begin
        div_yumi = 1'b0;
        unique case (state_q)
            StBusy:  div_yumi = cdb_req & cdb_gnt;
            StDrain: div_yumi = div_valid_out;
            default: div_yumi = 1'b0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    assign count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            rob_mem[wr_ptr_q] <= disp_rob;
            op_mem[wr_ptr_q]  <= disp_op;
            a_mem[wr_ptr_q]   <= disp_a;
            b_mem[wr_ptr_q]   <= disp_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) state_q <= StBusy;
                end
                StBusy: begin
                    if (flush) begin
                        state_q <= StDrain;
                    end else if (div_yumi) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (div_yumi) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Randomized scoreboard bench for div_scheduler: a behavioural divider drives the
// back end, expected issues and CDB broadcasts are queued and checked by a monitor.
module tb_div_scheduler;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [3:0]  rob;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] res;
    } cdb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_rob, disp_op;
    logic [31:0] disp_a, disp_b;
    logic        div_valid_in, div_ready;
    logic [3:0]  div_rob, div_op;
    logic [31:0] div_dividend, div_divisor;
    logic        div_valid_out;
    logic [3:0]  div_rob_done;
    logic [31:0] div_result;
    logic        div_yumi, cdb_req, cdb_gnt;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_result;
    logic        flush;
    logic [$clog2(DEPTH):0] count;

    div_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob(disp_rob),
        .disp_op(disp_op), .disp_a(disp_a), .disp_b(disp_b),
        .div_valid_in(div_valid_in), .div_ready(div_ready), .div_rob(div_rob),
        .div_op(div_op), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid_out(div_valid_out), .div_rob_done(div_rob_done),
        .div_result(div_result), .div_yumi(div_yumi),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_rob(cdb_rob), .cdb_result(cdb_result),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    op_t  exp_issue[$];
    cdb_t exp_cdb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural divider state (written by the stimulus process only).
    logic        hold = 1'b0, doomed = 1'b0;
    int          lat = 0;
    logic [3:0]  d_rob;
    logic [31:0] d_res;

    // Edge observations captured by the monitor for the divider model.
    logic iss_seen = 1'b0, yumi_seen = 1'b0, flush_seen = 1'b0;
    op_t  cap;

    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (op[0]) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'($signed(a) / $signed(b));
        end
        if (b == 32'd0) return a;
        return a % b;
    endfunction

    function automatic op_t mk(input int rob, input int op, input logic [31:0] a,
                               input logic [31:0] b);
        op_t o;
        o.rob = 4'(rob);
        o.op  = 4'(op);
        o.a   = a;
        o.b   = b;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic divider_update();
        if (!reset) begin
            hold = 1'b0;
            doomed = 1'b0;
            div_valid_out = 1'b0;
            return;
        end
        if (yumi_seen) begin
            hold = 1'b0;
            doomed = 1'b0;
            div_valid_out = 1'b0;
        end else if (hold && flush_seen) begin
            doomed = 1'b1;
        end
        if (iss_seen) begin
            hold  = 1'b1;
            lat   = $urandom_range(0, 3);
            d_rob = cap.rob;
            d_res = ref_div(cap.op, cap.a, cap.b);
        end else if (hold && !div_valid_out) begin
            if (lat == 0) begin
                div_valid_out = 1'b1;
                div_rob_done  = d_rob;
                div_result    = d_res;
            end else begin
                lat--;
            end
        end
    endtask

    // One cycle: drive at posedge+1, record the expected push after the monitor at posedge+7.
    task automatic step(input logic v, input op_t o, input logic fl, input logic gnt,
                        input logic stl);
        logic acc;
        @(posedge clk);
        #1;
        divider_update();
        div_ready  = ~hold & ~stl;
        disp_valid = v;
        disp_rob   = o.rob;
        disp_op    = o.op;
        disp_a     = o.a;
        disp_b     = o.b;
        flush      = fl;
        cdb_gnt    = gnt;
        acc = v & ~fl & reset & (exp_issue.size() < DEPTH);
        #7;
        if (acc) exp_issue.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, mk(0, 0, 0, 1), 1'b0, 1'b1, 1'b0);
    endtask

    logic exp_iss, exp_req, exp_yumi;
    op_t  e;
    cdb_t c;

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_disp_ready", 32'(disp_ready), 32'd1);
            chk("rst_div_valid_in", 32'(div_valid_in), 32'd0);
            chk("rst_div_yumi", 32'(div_yumi), 32'd0);
            chk("rst_cdb_req", 32'(cdb_req), 32'd0);
            exp_issue.delete();
            exp_cdb.delete();
            iss_seen = 1'b0;
            yumi_seen = 1'b0;
            flush_seen = 1'b0;
        end else begin
            exp_iss  = !hold && div_ready && exp_issue.size() != 0 && !flush;
            exp_req  = hold && div_valid_out && !doomed && !flush;
            exp_yumi = hold && div_valid_out && (doomed || (!flush && cdb_gnt));
            chk("count", 32'(count), 32'(exp_issue.size()));
            chk("disp_ready", 32'(disp_ready), 32'(exp_issue.size() < DEPTH));
            chk("div_valid_in", 32'(div_valid_in), 32'(exp_iss));
            chk("cdb_req", 32'(cdb_req), 32'(exp_req));
            chk("div_yumi", 32'(div_yumi), 32'(exp_yumi));
            if (exp_iss) begin
                e = exp_issue.pop_front();
                if (div_valid_in) begin
                    chk("issue_rob", 32'(div_rob), 32'(e.rob));
                    chk("issue_op", 32'(div_op), 32'(e.op));
                    chk("issue_a", div_dividend, e.a);
                    chk("issue_b", div_divisor, e.b);
                end
                c.rob = e.rob;
                c.res = ref_div(e.op, e.a, e.b);
                exp_cdb.push_back(c);
            end
            if (exp_req) begin
                if (exp_cdb.size() == 0) begin
                    chk("cdb_unexpected", 32'(cdb_req), 32'd0);
                end else begin
                    chk("cdb_rob", 32'(cdb_rob), 32'(exp_cdb[0].rob));
                    chk("cdb_result", cdb_result, exp_cdb[0].res);
                end
            end
            if (exp_yumi && exp_cdb.size() != 0) void'(exp_cdb.pop_front());
            if (flush) exp_issue.delete();
            iss_seen   = div_valid_in;
            yumi_seen  = div_yumi;
            flush_seen = flush;
            cap        = {div_rob, div_op, div_dividend, div_divisor};
        end
    end

    initial begin
        op_t o;
        reset = 1'b0;
        disp_valid = 1'b0; disp_rob = '0; disp_op = '0; disp_a = '0; disp_b = '0;
        div_ready = 1'b0; div_valid_out = 1'b0; div_rob_done = '0; div_result = '0;
        cdb_gnt = 1'b0; flush = 1'b0;
        idle(2);
        @(posedge clk);
        #2 reset = 1'b1;

        // Single signed divide: 100 / 7 = 14 broadcast on rob 3.
        step(1'b1, mk(3, 1, 100, 7), 1'b0, 1'b1, 1'b0);
        idle(8);

        // Fill with the divider stalled; the fifth op must be refused.
        for (int i = 0; i < 5; i++) step(1'b1, mk(i, 1, 32'(i * 10 + 1), 3), 1'b0, 1'b1, 1'b1);
        idle(16);

        // Result held without grant for several cycles.
        step(1'b1, mk(5, 0, 1000, 7), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, mk(0, 0, 0, 1), 1'b0, 1'b0, 1'b0);
        idle(4);

        // Flush while busy with two queued ops.
        for (int i = 0; i < 3; i++) step(1'b1, mk(8 + i, 0, 50, 6), 1'b0, 1'b1, 1'b1);
        step(1'b0, mk(0, 0, 0, 1), 1'b0, 1'b1, 1'b0);
        step(1'b0, mk(0, 0, 0, 1), 1'b1, 1'b1, 1'b0);
        idle(8);

        // Flush coinciding with a dispatch and an issue-eligible head.
        step(1'b1, mk(12, 1, 77, 5), 1'b0, 1'b1, 1'b1);
        step(1'b1, mk(13, 1, 88, 5), 1'b1, 1'b1, 1'b0);
        idle(4);

        // Asynchronous reset while busy with three queued.
        for (int i = 0; i < 4; i++) step(1'b1, mk(i, 0, 99, 4), 1'b0, 1'b1, 1'b1);
        step(1'b0, mk(0, 0, 0, 1), 1'b0, 1'b0, 1'b0);
        step(1'b0, mk(0, 0, 0, 1), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("async_rst_div_valid_in", 32'(div_valid_in), 32'd0);
        chk("async_rst_div_yumi", 32'(div_yumi), 32'd0);
        chk("async_rst_cdb_req", 32'(cdb_req), 32'd0);
        idle(2);
        @(posedge clk);
        #2 reset = 1'b1;
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            o.rob = 4'($urandom_range(0, 15));
            o.op  = 4'($urandom_range(0, 15));
            o.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom();
            o.b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom();
            step(1'($urandom_range(0, 2) != 0), o, 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
